uart_prog_loader: RTL and testbench

- Serial program loader at the far end of the host-to-board UART link: deserializes a framed byte stream from the host and writes it into the jacaranda-8 instruction memory.
- Holds the CPU in reset while loading and releases it only after a verified checksum.
- Sits between the board rx pin and the instruction memory write port, in parallel with the runtime UART peripheral.
- Line format is the same as the runtime UART: 115200 bps, 8 data bits, LSB first, no parity, 1 stop bit.

---
 rtl/uart_prog_loader.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : Serial program loader for the jacaranda-8 instruction memory.
//               Receives 8N1 frames on rx, interprets the stream as
//               [N][N data bytes][checksum], writes the data bytes to
//               consecutive instruction-memory addresses starting at 0 and
//               keeps the CPU in reset until the checksum has been verified.
//
// Ports       : clk        - system clock, all logic on posedge
//               reset      - asynchronous active-high reset
//               rx         - serial line (idle high), asynchronous to clk
//               clk_freq   - clk frequency in Hz (quasi-static)
//               load_en    - 1 = loader armed, 0 = abort / return to idle
//               imem_w_en  - one-cycle instruction memory write strobe
//               imem_addr  - write address (holds between strobes)
//               imem_data  - write data (holds between strobes)
//               cpu_hold   - 1 = keep CPU in reset
//               done       - load completed and checksum matched
//               error      - framing or checksum failure
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
    parameter int BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [31:0] clk_freq,
    input  logic        load_en,
    output logic        imem_w_en,
    output logic [7:0]  imem_addr,
    output logic [7:0]  imem_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] C_BAUD       = 32'(BAUD_RATE);
    localparam logic [31:0] C_MIN_PERIOD = 32'd2;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE = 3'd0,
        L_LEN  = 3'd1,
        L_DATA = 3'd2,
        L_SUM  = 3'd3,
        L_DONE = 3'd4,
        L_ERR  = 3'd5
    } load_state_t;

    // ------------------------------------------------------------------
    // Bit period. clk_freq is quasi-static, so the divider result is
    // registered to keep the divide out of the counter compare paths.
    // ------------------------------------------------------------------
    logic [31:0] w_div;
    logic [31:0] w_period;
    logic [31:0] r_period;
    logic [31:0] w_per_last;
    logic [31:0] w_half_last;

    assign w_div      = clk_freq / C_BAUD;
    assign w_period   = (w_div < C_MIN_PERIOD) ? C_MIN_PERIOD : w_div;
    assign w_per_last = r_period - 32'd1;
    // r_period >= 2, so the half period is at least 1 and this cannot underflow
    assign w_half_last = (r_period >> 1) - 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period <= C_MIN_PERIOD;
        end else begin
            r_period <= w_period;
        end
    end

    // ------------------------------------------------------------------
    // rx synchronizer and falling-edge detect. Flops reset to the idle
    // level so leaving reset never looks like a start edge.
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_rx_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // ------------------------------------------------------------------
    // Deserializer
    // ------------------------------------------------------------------
    load_state_t r_state;
    load_state_t w_state_next;

    rx_state_t   r_rx_state;
    rx_state_t   w_rx_next;
    logic [31:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_byte_valid;
    logic        r_frame_err;
    logic        w_rx_run;
    logic        w_bit_tick;
    logic        w_stop_tick;

    assign w_rx_run = (r_state == L_LEN) || (r_state == L_DATA) || (r_state == L_SUM);

    always_comb begin
        w_rx_next   = r_rx_state;
        w_bit_tick  = 1'b0;
        w_stop_tick = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_next = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit check: a high line here was only a glitch
                if (r_cnt == w_half_last) begin
                    w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == w_per_last) begin
                    w_bit_tick = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_rx_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_cnt == w_per_last) begin
                    w_stop_tick = 1'b1;
                    w_rx_next   = RX_IDLE;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
        if (!w_rx_run) begin
            w_rx_next   = RX_IDLE;
            w_bit_tick  = 1'b0;
            w_stop_tick = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            // Counter restarts on every state change and every data sample,
            // so each sample lands one full period after the previous one.
            if ((w_rx_next != r_rx_state) || w_bit_tick) begin
                r_cnt <= '0;
            end else if (r_rx_state != RX_IDLE) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (r_rx_state == RX_IDLE) begin
                r_idx <= '0;
            end else if (w_bit_tick) begin
                r_idx <= r_idx + 3'd1;
            end

            // LSB first: shift in from the top
            if (w_bit_tick) begin
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end

            r_byte_valid <= w_stop_tick &  r_rx_sync;
            r_frame_err  <= w_stop_tick & ~r_rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    logic [8:0] r_remain;
    logic [7:0] r_ptr;
    logic [7:0] r_acc;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic       r_w_en;
    logic       w_wr;

    always_comb begin
        w_state_next = r_state;
        w_wr         = 1'b0;
        case (r_state)
            L_IDLE: begin
                if (load_en) begin
                    w_state_next = L_LEN;
                end
            end
            L_LEN: begin
                if (!load_en) begin
                    w_state_next = L_IDLE;
                end else if (r_frame_err) begin
                    w_state_next = L_ERR;
                end else if (r_byte_valid) begin
                    w_state_next = L_DATA;
                end
            end
            L_DATA: begin
                // Abort takes priority over a byte arriving in the same cycle
                if (!load_en) begin
                    w_state_next = L_IDLE;
                end else if (r_frame_err) begin
                    w_state_next = L_ERR;
                end else if (r_byte_valid) begin
                    w_wr = 1'b1;
                    if (r_remain == 9'd1) begin
                        w_state_next = L_SUM;
                    end
                end
            end
            L_SUM: begin
                if (!load_en) begin
                    w_state_next = L_IDLE;
                end else if (r_frame_err) begin
                    w_state_next = L_ERR;
                end else if (r_byte_valid) begin
                    w_state_next = (r_shift == r_acc) ? L_DONE : L_ERR;
                end
            end
            L_DONE, L_ERR: begin
                if (!load_en) begin
                    w_state_next = L_IDLE;
                end
            end
            default: w_state_next = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= L_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remain <= '0;
            r_ptr    <= '0;
            r_acc    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_w_en   <= 1'b0;
        end else begin
            r_w_en <= w_wr;

            if ((r_state == L_IDLE) && load_en) begin
                r_ptr  <= '0;
                r_acc  <= '0;
                r_addr <= '0;
            end

            // A length byte of 0 encodes a full 256-byte image
            if ((r_state == L_LEN) && (w_state_next == L_DATA)) begin
                r_remain <= (r_shift == 8'd0) ? 9'd256 : {1'b0, r_shift};
            end

            // r_ptr wraps to 0 after the 256th write, but no write follows it
            if (w_wr) begin
                r_addr   <= r_ptr;
                r_data   <= r_shift;
                r_ptr    <= r_ptr + 8'd1;
                r_acc    <= r_acc + r_shift;
                r_remain <= r_remain - 9'd1;
            end
        end
    end

    assign imem_w_en = r_w_en;
    assign imem_addr = r_addr;
    assign imem_data = r_data;
    assign cpu_hold  = (r_state == L_LEN) || (r_state == L_DATA) ||
                       (r_state == L_SUM) || (r_state == L_ERR);
    assign done      = (r_state == L_DONE);
    assign error     = (r_state == L_ERR);

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_prog_loader
// Description : Directed self-checking bench for uart_prog_loader. Drives
//               8N1 frames at P = 10 clocks per bit and checks the write
//               trace and status outputs against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;

    localparam int P = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [31:0] clk_freq;
    logic        load_en;
    logic        imem_w_en;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    uart_prog_loader #(
        .BAUD_RATE (115200)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .clk_freq  (clk_freq),
        .load_en   (load_en),
        .imem_w_en (imem_w_en),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Write trace {addr, data} and protocol watchers, sampled on the falling edge
    logic [15:0] wq[$];
    int          strobe_long = 0;
    int          both_hi     = 0;
    logic        prev_wen    = 1'b0;

    always @(negedge clk) begin
        if (imem_w_en) wq.push_back({imem_addr, imem_data});
        if (imem_w_en && prev_wen) strobe_long <= strobe_long + 1;
        if (done && error) both_hi <= both_hi + 1;
        prev_wen <= imem_w_en;
    end

    function automatic logic [15:0] wq_at(input int i);
        if (i < wq.size()) return wq[i];
        return 16'hxxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(P);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(P);
        end
        rx = stop_bit;
        tick(P);
        rx = 1'b1;
        tick(2);
    endtask

    initial begin
        int bad;
        reset    = 1'b1;
        rx       = 1'b1;
        load_en  = 1'b0;
        clk_freq = 32'd1152000;
        tick(3);
        chk("reset_outputs", {imem_w_en, imem_addr, imem_data, cpu_hold, done, error}, 32'h0);
        reset = 1'b0;
        tick(2);
        chk("idle_no_hold", {cpu_hold, done, error}, 32'h0);

        // ---------------- nominal load ----------------
        load_en = 1'b1;
        tick(2);
        chk("len_hold", {cpu_hold, done, error}, 32'b100);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        tick(4);
        chk("nom_nwrites", wq.size(), 32'd3);
        chk("nom_w0", wq_at(0), 32'h0011);
        chk("nom_w1", wq_at(1), 32'h0122);
        chk("nom_w2", wq_at(2), 32'h0233);
        chk("nom_in_sum", {cpu_hold, done, error}, 32'b100);
        send_byte(8'h66, 1'b1);
        tick(4);
        chk("nom_done", {cpu_hold, done, error}, 32'b010);
        chk("nom_no_extra", wq.size(), 32'd3);
        load_en = 1'b0;
        tick(2);
        chk("nom_release", {cpu_hold, done, error}, 32'h0);
        wq.delete();

        // ---------------- bad checksum ----------------
        load_en = 1'b1;
        tick(2);
        send_byte(8'h02, 1'b1);
        send_byte(8'hA0, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(4);
        chk("bad_nwrites", wq.size(), 32'd2);
        chk("bad_w0", wq_at(0), 32'h00A0);
        chk("bad_w1", wq_at(1), 32'h0101);
        chk("bad_err", {cpu_hold, done, error}, 32'b101);
        load_en = 1'b0;
        tick(2);
        chk("bad_release", {cpu_hold, done, error}, 32'h0);
        chk("bad_addr_data_hold", {imem_addr, imem_data}, 32'h0101);
        wq.delete();

        // ---------------- framing error ----------------
        load_en = 1'b1;
        tick(2);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        chk("frm_err", {cpu_hold, done, error}, 32'b101);
        chk("frm_nowrite", wq.size(), 32'd0);
        load_en = 1'b0;
        tick(2);
        chk("frm_release", {cpu_hold, done, error}, 32'h0);

        // ---------------- start glitch + 256-byte load ----------------
        load_en = 1'b1;
        tick(2);
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3 * P);
        chk("glitch_quiet", {cpu_hold, done, error}, 32'b100);
        chk("glitch_nowrite", wq.size(), 32'd0);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(4);
        chk("full_nwrites", wq.size(), 32'd256);
        chk("full_first", wq_at(0), 32'h0001);
        chk("full_last", wq_at(255), 32'hFF01);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (wq_at(i) !== {8'(i), 8'h01}) bad++;
        end
        chk("full_sequence", bad, 32'd0);
        chk("full_done", {cpu_hold, done, error}, 32'b010);
        load_en = 1'b0;
        tick(2);
        wq.delete();

        // ---------------- abort ----------------
        load_en = 1'b1;
        tick(2);
        send_byte(8'h04, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        tick(3);
        chk("abort_two_writes", wq.size(), 32'd2);
        chk("abort_w1", wq_at(1), 32'h01BB);
        load_en = 1'b0;
        tick(1);
        chk("abort_drop", {cpu_hold, done, error}, 32'h0);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        tick(4);
        chk("abort_no_more", wq.size(), 32'd2);
        wq.delete();

        // ---------------- async reset mid-byte ----------------
        load_en = 1'b1;
        tick(2);
        send_byte(8'h02, 1'b1);
        send_byte(8'h5A, 1'b1);
        tick(3);
        chk("pre_reset_w0", wq_at(0), 32'h005A);
        rx = 1'b0;
        tick(3 * P);
        rx = 1'b1;
        tick(P / 2);
        #2 reset = 1'b1;
        #1 chk("async_reset", {imem_w_en, imem_addr, imem_data, cpu_hold, done, error}, 32'h0);
        rx = 1'b1;
        tick(2);
        reset = 1'b0;
        wq.delete();
        tick(2);
        chk("post_reset_len", {cpu_hold, done, error}, 32'b100);
        tick(2 * P);
        send_byte(8'h02, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b1);
        tick(4);
        chk("reload_nwrites", wq.size(), 32'd2);
        chk("reload_w0", wq_at(0), 32'h0010);
        chk("reload_w1", wq_at(1), 32'h0120);
        chk("reload_done", {cpu_hold, done, error}, 32'b010);
        load_en = 1'b0;
        tick(2);

        chk("strobe_one_cycle", strobe_long, 32'd0);
        chk("done_error_exclusive", both_hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
